// File: rtl/game_sequencer.sv
// Lights-out style 4x4 grid sequencer: scrambles the board with LFSR-driven
// row/col fires on start, then hands the shared cell bus to the player.
// Ports: clk_i, reset_ni (async, active low), start_i, player_sel_i,
//   player_nRow_i, player_error_i, player_fire_i, player_add_n_i, win_i
//   in; row_o, col_o, fire_o, add_n_o, busy_o, won_o, lost_o,
//   move_count_o out (all registered).
// Optional: define GAME_SEQUENCER_MOVE_LIMIT_EN to build the LOST state,
//   entered when move_count reaches MAX_MOVES without a win.
module game_sequencer #(
  parameter int          SCRAMBLE_MOVES = 8,
  parameter int          FIRE_GAP       = 4,
  parameter logic [15:0] SEED           = 16'hACE1,
  parameter int          MOVE_W         = 8,
  parameter int          MAX_MOVES      = 32
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              start_i,
  input  logic [3:0]        player_sel_i,
  input  logic              player_nRow_i,
  input  logic              player_error_i,
  input  logic              player_fire_i,
  input  logic              player_add_n_i,
  input  logic              win_i,
  output logic [3:0]        row_o,
  output logic [3:0]        col_o,
  output logic              fire_o,
  output logic              add_n_o,
  output logic              busy_o,
  output logic              won_o,
  output logic              lost_o,
  output logic [MOVE_W-1:0] move_count_o
);

  localparam int GW = $clog2(FIRE_GAP + 1);
  localparam logic [GW-1:0] GapInit = GW'(FIRE_GAP - 1);
  localparam logic [7:0] ScrInit = 8'(SCRAMBLE_MOVES);
`ifdef GAME_SEQUENCER_MOVE_LIMIT_EN
  localparam logic [MOVE_W-1:0] MaxMv = MOVE_W'(MAX_MOVES);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_FIRE,
    S_GAP,
    S_CHECK,
    S_PLAY,
    S_WON
`ifdef GAME_SEQUENCER_MOVE_LIMIT_EN
    , S_LOST
`endif
  } state_e;

  state_e state_q, state_d;

  logic [15:0]       lfsr_q, lfsr_d;
  logic [7:0]        scr_q, scr_d;
  logic [GW-1:0]     gap_q, gap_d;
  // Player fire pipeline: 1 = selection on bus, 2 = fire pulse on bus.
  logic [1:0]        pf_q, pf_d;
  logic [MOVE_W-1:0] mc_q, mc_d;
  logic [3:0]        row_q, row_d;
  logic [3:0]        col_q, col_d;
  logic              fire_q, fire_d;
  logic              addn_q, addn_d;
  logic              busy_q, busy_d;
  logic              won_q, won_d;
  logic              setup_entry;
  logic              p_valid;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    lfsr_step = v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start_i) begin
      state_d = S_SETUP;
    end else begin
      case (state_q)
        S_IDLE:  state_d = S_IDLE;
        S_SETUP: state_d = S_FIRE;
        S_FIRE:  state_d = S_GAP;
        S_GAP: begin
          if (gap_q == '0)
            state_d = (scr_q != 8'd0) ? S_SETUP : S_CHECK;
        end
        S_CHECK: state_d = win_i ? S_SETUP : S_PLAY;
        S_PLAY: begin
          // Only leave play once the bus has drained.
          if (pf_q == 2'd0) begin
            if (win_i) state_d = S_WON;
`ifdef GAME_SEQUENCER_MOVE_LIMIT_EN
            else if (mc_q >= MaxMv) state_d = S_LOST;
`endif
          end
        end
        S_WON: state_d = S_WON;
`ifdef GAME_SEQUENCER_MOVE_LIMIT_EN
        S_LOST: state_d = S_LOST;
`endif
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign p_valid = player_fire_i && !player_error_i
                && (player_sel_i != 4'd0);

  always_comb begin
    lfsr_d = lfsr_q;
    scr_d  = scr_q;
    gap_d  = gap_q;
    pf_d   = 2'd0;
    mc_d   = mc_q;
    row_d  = 4'd0;
    col_d  = 4'd0;
    fire_d = 1'b0;
    addn_d = addn_q;
    setup_entry = (state_d == S_SETUP)
               && (start_i || state_q != S_SETUP);
    if (start_i) begin
      scr_d = ScrInit;
      mc_d  = '0;
    end
    if (setup_entry) lfsr_d = lfsr_step(lfsr_q);
    // Already-solved scramble: queue exactly one more move.
    if (!start_i && state_q == S_CHECK && state_d == S_SETUP)
      scr_d = 8'd1;
    case (state_d)
      S_SETUP: begin
        addn_d = 1'b0;
        if (lfsr_d[2]) col_d = 4'b0001 << lfsr_d[1:0];
        else           row_d = 4'b0001 << lfsr_d[1:0];
      end
      S_FIRE: begin
        row_d  = row_q;
        col_d  = col_q;
        fire_d = 1'b1;
      end
      S_GAP: begin
        if (state_q != S_GAP) begin
          gap_d = GapInit;
          scr_d = scr_q - 8'd1;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      S_PLAY: begin
        if (state_q == S_PLAY) begin
          if (pf_q == 2'd1) begin
            row_d  = row_q;
            col_d  = col_q;
            fire_d = 1'b1;
            pf_d   = 2'd2;
            mc_d   = (&mc_q) ? mc_q : mc_q + 1'b1;
          end else if (pf_q == 2'd0 && p_valid) begin
            pf_d   = 2'd1;
            addn_d = player_add_n_i;
            if (player_nRow_i) col_d = player_sel_i;
            else               row_d = player_sel_i;
          end
        end
      end
      default: ;
    endcase
    busy_d = (state_d == S_SETUP) || (state_d == S_FIRE)
          || (state_d == S_GAP);
    won_d  = (state_d == S_WON);
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      lfsr_q <= SEED;
      scr_q  <= 8'd0;
      gap_q  <= '0;
      pf_q   <= 2'd0;
      mc_q   <= '0;
      row_q  <= 4'd0;
      col_q  <= 4'd0;
      fire_q <= 1'b0;
      addn_q <= 1'b0;
      busy_q <= 1'b0;
      won_q  <= 1'b0;
    end else begin
      lfsr_q <= lfsr_d;
      scr_q  <= scr_d;
      gap_q  <= gap_d;
      pf_q   <= pf_d;
      mc_q   <= mc_d;
      row_q  <= row_d;
      col_q  <= col_d;
      fire_q <= fire_d;
      addn_q <= addn_d;
      busy_q <= busy_d;
      won_q  <= won_d;
    end
  end

`ifdef GAME_SEQUENCER_MOVE_LIMIT_EN
  logic lost_q;
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) lost_q <= 1'b0;
    else           lost_q <= (state_d == S_LOST);
  end
  assign lost_o = lost_q;
`else
  assign lost_o = 1'b0;
`endif

  assign row_o        = row_q;
  assign col_o        = col_q;
  assign fire_o       = fire_q;
  assign add_n_o      = addn_q;
  assign busy_o       = busy_q;
  assign won_o        = won_q;
  assign move_count_o = mc_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer: scramble sequence vs LFSR reference,
// player fire path, win/lost handling, start abort and async reset.
module tb_game_sequencer;

  logic       clk = 1'b0;
  logic       reset_ni;
  logic       start_i;
  logic [3:0] player_sel_i;
  logic       player_nRow_i;
  logic       player_error_i;
  logic       player_fire_i;
  logic       player_add_n_i;
  logic       win_i;
  logic [3:0] row_o;
  logic [3:0] col_o;
  logic       fire_o;
  logic       add_n_o;
  logic       busy_o;
  logic       won_o;
  logic       lost_o;
  logic [7:0] move_count_o;

  int n_cmp = 0;
  int n_err = 0;
  int busy_cnt;
  int fire_cnt;
  logic [15:0] m_lfsr;

  always #5 clk = ~clk;

  game_sequencer #(
    .SCRAMBLE_MOVES(8),
    .FIRE_GAP(4),
    .SEED(16'hACE1),
    .MOVE_W(8),
    .MAX_MOVES(3)
  ) dut (
    .clk_i(clk),
    .reset_ni(reset_ni),
    .start_i(start_i),
    .player_sel_i(player_sel_i),
    .player_nRow_i(player_nRow_i),
    .player_error_i(player_error_i),
    .player_fire_i(player_fire_i),
    .player_add_n_i(player_add_n_i),
    .win_i(win_i),
    .row_o(row_o),
    .col_o(col_o),
    .fire_o(fire_o),
    .add_n_o(add_n_o),
    .busy_o(busy_o),
    .won_o(won_o),
    .lost_o(lost_o),
    .move_count_o(move_count_o)
  );

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [15:0] lstep(input logic [15:0] v);
    lstep = v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  // Entered at a SETUP cycle; leaves at the cycle after the last GAP.
  task automatic run_scramble(input int n);
    logic [3:0] er, ec, one;
    for (int i = 0; i < n; i++) begin
      m_lfsr = lstep(m_lfsr);
      one = 4'b0001;
      er = m_lfsr[2] ? 4'd0 : (one << m_lfsr[1:0]);
      ec = m_lfsr[2] ? (one << m_lfsr[1:0]) : 4'd0;
      n_cmp++;
      if ({row_o, col_o, fire_o, busy_o, add_n_o}
          !== {er, ec, 1'b0, 1'b1, 1'b0}) begin
        n_err++;
        $display("FAIL setup%0d: row=%b col=%b f=%b b=%b a=%b exp row=%b col=%b f=0 b=1 a=0",
                 i, row_o, col_o, fire_o, busy_o, add_n_o, er, ec);
      end
      if (busy_o) busy_cnt++;
      tick();
      n_cmp++;
      if ({row_o, col_o, fire_o, busy_o} !== {er, ec, 1'b1, 1'b1}) begin
        n_err++;
        $display("FAIL fire%0d: row=%b col=%b f=%b b=%b exp row=%b col=%b f=1 b=1",
                 i, row_o, col_o, fire_o, busy_o, er, ec);
      end
      if (fire_o) fire_cnt++;
      if (busy_o) busy_cnt++;
      for (int g = 0; g < 4; g++) begin
        tick();
        n_cmp++;
        if ({row_o, col_o, fire_o, busy_o} !== {8'd0, 1'b0, 1'b1}) begin
          n_err++;
          $display("FAIL gap%0d.%0d: row=%b col=%b f=%b b=%b exp 0 0 0 1",
                   i, g, row_o, col_o, fire_o, busy_o);
        end
        if (busy_o) busy_cnt++;
        if (fire_o) fire_cnt++;
      end
      tick();
    end
  endtask

  task automatic check_idle_bus(input string nm);
    n_cmp++;
    if ({busy_o, fire_o, row_o, col_o} !== 10'd0) begin
      n_err++;
      $display("FAIL %s: busy=%b fire=%b row=%b col=%b exp all 0",
               nm, busy_o, fire_o, row_o, col_o);
    end
  endtask

  task automatic fire_once(input logic [3:0] sel);
    player_sel_i  = sel;
    player_nRow_i = 1'b0;
    player_fire_i = 1'b1;
    tick();
    player_fire_i = 1'b0;
    tick();
    tick();
    tick();
  endtask

  task automatic test_reset;
    reset_ni = 1'b0;
    start_i = 1'b0;
    player_sel_i = 4'd0;
    player_nRow_i = 1'b0;
    player_error_i = 1'b0;
    player_fire_i = 1'b0;
    player_add_n_i = 1'b0;
    win_i = 1'b0;
    tick();
    tick();
    n_cmp++;
    if ({row_o, col_o, fire_o, add_n_o} !== 10'd0) begin
      n_err++;
      $display("FAIL reset_bus: row=%b col=%b f=%b a=%b exp 0",
               row_o, col_o, fire_o, add_n_o);
    end
    n_cmp++;
    if ({busy_o, won_o, lost_o, move_count_o} !== 11'd0) begin
      n_err++;
      $display("FAIL reset_status: b=%b w=%b l=%b mc=%0d exp 0",
               busy_o, won_o, lost_o, move_count_o);
    end
    reset_ni = 1'b1;
    m_lfsr = 16'hACE1;
    tick();
    tick();
    check_idle_bus("idle_after_reset");
  endtask

  task automatic test_scramble;
    pulse_start();
    busy_cnt = 0;
    fire_cnt = 0;
    run_scramble(8);
    n_cmp++;
    if (fire_cnt !== 8) begin
      n_err++;
      $display("FAIL scramble_fires: got %0d exp 8", fire_cnt);
    end
    n_cmp++;
    if (busy_cnt !== 48) begin
      n_err++;
      $display("FAIL scramble_busy: got %0d exp 48", busy_cnt);
    end
    check_idle_bus("check_state");
    tick();
    check_idle_bus("play_entry");
    n_cmp++;
    if (move_count_o !== 8'd0) begin
      n_err++;
      $display("FAIL play_mc: got %0d exp 0", move_count_o);
    end
  endtask

  task automatic test_player_fire;
    player_sel_i = 4'b0100;
    player_nRow_i = 1'b1;
    player_add_n_i = 1'b1;
    player_fire_i = 1'b1;
    tick();
    player_fire_i = 1'b0;
    n_cmp++;
    if ({row_o, col_o, fire_o, add_n_o}
        !== {4'b0000, 4'b0100, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL pf_sel: row=%b col=%b f=%b a=%b exp 0000 0100 0 1",
               row_o, col_o, fire_o, add_n_o);
    end
    tick();
    n_cmp++;
    if ({col_o, fire_o, move_count_o}
        !== {4'b0100, 1'b1, 8'd1}) begin
      n_err++;
      $display("FAIL pf_fire: col=%b f=%b mc=%0d exp 0100 1 1",
               col_o, fire_o, move_count_o);
    end
    tick();
    n_cmp++;
    if ({col_o, fire_o} !== 5'd0) begin
      n_err++;
      $display("FAIL pf_done: col=%b f=%b exp 0000 0", col_o, fire_o);
    end
  endtask

  task automatic test_invalid_fire;
    int fc;
    player_add_n_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      fc = 0;
      player_error_i = (k == 0);
      player_sel_i = (k == 0) ? 4'b0001 : 4'b0000;
      player_fire_i = 1'b1;
      tick();
      player_fire_i = 1'b0;
      player_error_i = 1'b0;
      for (int c = 0; c < 3; c++) begin
        if (fire_o || row_o != 4'd0 || col_o != 4'd0) fc++;
        tick();
      end
      n_cmp++;
      if (fc !== 0 || move_count_o !== 8'd1) begin
        n_err++;
        $display("FAIL invalid%0d: bus_active=%0d mc=%0d exp 0 1",
                 k, fc, move_count_o);
      end
    end
    fc = 0;
    player_sel_i = 4'b0010;
    player_nRow_i = 1'b0;
    player_fire_i = 1'b1;
    tick();
    n_cmp++;
    if (row_o !== 4'b0010) begin
      n_err++;
      $display("FAIL b2b_sel: row=%b exp 0010", row_o);
    end
    tick();
    player_fire_i = 1'b0;
    if (fire_o) fc++;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (fire_o) fc++;
    end
    n_cmp++;
    if (fc !== 1 || move_count_o !== 8'd2) begin
      n_err++;
      $display("FAIL b2b: fires=%0d mc=%0d exp 1 2", fc, move_count_o);
    end
  endtask

  task automatic test_win_play;
    int act;
    win_i = 1'b1;
    tick();
    n_cmp++;
    if ({won_o, busy_o} !== 2'b10) begin
      n_err++;
      $display("FAIL won: won=%b busy=%b exp 1 0", won_o, busy_o);
    end
    act = 0;
    player_sel_i = 4'b0001;
    player_fire_i = 1'b1;
    tick();
    player_fire_i = 1'b0;
    win_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (fire_o || row_o != 4'd0 || col_o != 4'd0) act++;
      tick();
    end
    n_cmp++;
    if (act !== 0 || move_count_o !== 8'd2 || won_o !== 1'b1) begin
      n_err++;
      $display("FAIL won_hold: bus_active=%0d mc=%0d won=%b exp 0 2 1",
               act, move_count_o, won_o);
    end
  endtask

  task automatic test_check_win;
    pulse_start();
    n_cmp++;
    if ({won_o, busy_o, move_count_o} !== {1'b0, 1'b1, 8'd0}) begin
      n_err++;
      $display("FAIL restart: won=%b busy=%b mc=%0d exp 0 1 0",
               won_o, busy_o, move_count_o);
    end
    run_scramble(8);
    win_i = 1'b1;
    tick();
    win_i = 1'b0;
    fire_cnt = 0;
    run_scramble(1);
    n_cmp++;
    if (fire_cnt !== 1) begin
      n_err++;
      $display("FAIL extra_fire: got %0d exp 1", fire_cnt);
    end
    check_idle_bus("check_after_extra");
    tick();
    tick();
    check_idle_bus("play_after_extra");
  endtask

  task automatic test_start_abort;
    logic [3:0] er, ec, one;
    pulse_start();
    run_scramble(2);
    m_lfsr = lstep(m_lfsr);
    one = 4'b0001;
    er = m_lfsr[2] ? 4'd0 : (one << m_lfsr[1:0]);
    ec = m_lfsr[2] ? (one << m_lfsr[1:0]) : 4'd0;
    tick();
    n_cmp++;
    if ({row_o, col_o, fire_o} !== {er, ec, 1'b1}) begin
      n_err++;
      $display("FAIL abort_fire3: row=%b col=%b f=%b exp %b %b 1",
               row_o, col_o, fire_o, er, ec);
    end
    tick();
    tick();
    pulse_start();
    n_cmp++;
    if ({fire_o, busy_o} !== 2'b01) begin
      n_err++;
      $display("FAIL abort_setup: f=%b b=%b exp 0 1", fire_o, busy_o);
    end
    fire_cnt = 0;
    run_scramble(8);
    n_cmp++;
    if (fire_cnt !== 8) begin
      n_err++;
      $display("FAIL abort_reload: fires=%0d exp 8", fire_cnt);
    end
    check_idle_bus("abort_check");
    tick();
  endtask

  task automatic test_reset_mid_fire;
    pulse_start();
    m_lfsr = lstep(m_lfsr);
    tick();
    n_cmp++;
    if (fire_o !== 1'b1) begin
      n_err++;
      $display("FAIL rst_pre: fire=%b exp 1", fire_o);
    end
    #2;
    reset_ni = 1'b0;
    #1;
    n_cmp++;
    if ({row_o, col_o, fire_o, add_n_o, busy_o, won_o, lost_o,
         move_count_o} !== 22'd0) begin
      n_err++;
      $display("FAIL rst_async: row=%b col=%b f=%b b=%b mc=%0d exp 0",
               row_o, col_o, fire_o, busy_o, move_count_o);
    end
    tick();
    reset_ni = 1'b1;
    m_lfsr = 16'hACE1;
    tick();
    check_idle_bus("rst_idle");
    pulse_start();
    fire_cnt = 0;
    run_scramble(8);
    tick();
    check_idle_bus("rst_replay");
  endtask

`ifdef GAME_SEQUENCER_MOVE_LIMIT_EN
  task automatic test_move_limit;
    for (int i = 0; i < 3; i++) begin
      fire_once(4'b1000);
      n_cmp++;
      if (lost_o !== (i == 2)) begin
        n_err++;
        $display("FAIL lost%0d: lost=%b exp %b", i, lost_o, (i == 2));
      end
    end
    n_cmp++;
    if ({won_o, busy_o, move_count_o} !== {1'b0, 1'b0, 8'd3}) begin
      n_err++;
      $display("FAIL lost_state: won=%b busy=%b mc=%0d exp 0 0 3",
               won_o, busy_o, move_count_o);
    end
    pulse_start();
    run_scramble(8);
    tick();
    fire_once(4'b0001);
    fire_once(4'b0001);
    player_sel_i = 4'b0001;
    player_fire_i = 1'b1;
    tick();
    player_fire_i = 1'b0;
    tick();
    win_i = 1'b1;
    tick();
    tick();
    win_i = 1'b0;
    n_cmp++;
    if ({won_o, lost_o, move_count_o} !== {1'b1, 1'b0, 8'd3}) begin
      n_err++;
      $display("FAIL win_prio: won=%b lost=%b mc=%0d exp 1 0 3",
               won_o, lost_o, move_count_o);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_scramble();
    test_player_fire();
    test_invalid_fire();
    test_win_play();
    test_check_win();
    test_start_abort();
    test_reset_mid_fire();
`ifdef GAME_SEQUENCER_MOVE_LIMIT_EN
    test_move_limit();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
